// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with shared counter and double-buffered duties
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       run control; low holds the counter at 0 and forces outputs low
//   data_in      packed signed samples, channel k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   data_valid   data_in valid
//   data_ready   shadow buffer free; transfer on data_valid && data_ready
//   pwm_out      registered PWM outputs, one per channel
//   period_start one-cycle pulse aligned with the count-0 output cycle
module pwm_multi #(
  parameter int NUM_CH         = 2,
  parameter int INPUT_WIDTH    = 12,
  parameter int COUNTER_WIDTH  = 10,
  parameter int OFFSET         = 512,
  parameter int CENTER_ALIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CH*INPUT_WIDTH-1:0] data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic                          period_start
);

  localparam int CW = COUNTER_WIDTH;
  localparam int DW = COUNTER_WIDTH + 1;
  localparam int SW = INPUT_WIDTH + 2;
  localparam int FULL = 1 << COUNTER_WIDTH;
  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] count, count_next;
  logic          dir_up, dir_up_next;
  logic [DW-1:0] active_duty [NUM_CH];
  logic [DW-1:0] shadow_duty [NUM_CH];
  logic [DW-1:0] dn [NUM_CH];
  logic          pending;
  logic          out_of_reset;
  logic          boundary;
  logic          transfer;

  // Signed sample plus offset, clamped to [0, 2^COUNTER_WIDTH].
  function automatic logic [DW-1:0] to_duty(input logic [INPUT_WIDTH-1:0] x);
    logic signed [SW-1:0] s;
    int                   s_i;
    s   = SW'($signed(x)) + SW'(OFFSET);
    s_i = int'(s);
    if (s_i < 0)
      return '0;
    else if (s_i > FULL)
      return DW'(FULL);
    else
      return DW'(s_i);
  endfunction

  assign boundary = enable && (count == '0) && dir_up;
  assign transfer = data_valid && data_ready;
  // out_of_reset keeps ready low through the reset cycles without a path from rst.
  assign data_ready = out_of_reset && !pending;

  // Counter next state. In center mode the down leg turns back to up as it
  // enters 0, so count 0 with direction up marks every period start.
  always_comb begin
    count_next  = count;
    dir_up_next = dir_up;
    if (!enable) begin
      count_next  = '0;
      dir_up_next = 1'b1;
    end else if (CENTER_ALIGNED == 0) begin
      count_next = count + 1'b1;
    end else if (dir_up) begin
      if (count == MAX) begin
        count_next  = MAX - 1'b1;
        dir_up_next = 1'b0;
      end else begin
        count_next = count + 1'b1;
      end
    end else begin
      count_next = count - 1'b1;
      if (count == CW'(1))
        dir_up_next = 1'b1;
    end
  end

  // Duty used for this cycle's compare: a pending shadow takes effect on the
  // boundary cycle itself so the first output of the period already uses it.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      dn[k] = (boundary && pending) ? shadow_duty[k] : active_duty[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      dir_up       <= 1'b1;
      pending      <= 1'b0;
      out_of_reset <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        active_duty[k] <= '0;
        shadow_duty[k] <= '0;
      end
    end else begin
      count        <= count_next;
      dir_up       <= dir_up_next;
      out_of_reset <= 1'b1;
      period_start <= boundary;
      for (int k = 0; k < NUM_CH; k++) begin
        pwm_out[k] <= enable && ({1'b0, count} < dn[k]);
        if (boundary && pending)
          active_duty[k] <= shadow_duty[k];
        if (transfer)
          shadow_duty[k] <= to_duty(data_in[k*INPUT_WIDTH +: INPUT_WIDTH]);
      end
      // A transfer needs pending=0, so it never collides with a boundary load.
      if (transfer)
        pending <= 1'b1;
      else if (boundary)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi in edge and center modes
module tb_pwm_multi;

  localparam int MAXV = 15;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] e_data, c_data;
  logic        e_valid, c_valid;
  logic        e_ready, c_ready;
  logic [1:0]  e_pwm, c_pwm;
  logic        e_ps, c_ps;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  pwm_multi #(.NUM_CH(2), .INPUT_WIDTH(6), .COUNTER_WIDTH(4), .OFFSET(8), .CENTER_ALIGNED(0)) u_edge (
    .clk(clk), .rst(rst), .enable(enable), .data_in(e_data), .data_valid(e_valid),
    .data_ready(e_ready), .pwm_out(e_pwm), .period_start(e_ps));

  pwm_multi #(.NUM_CH(2), .INPUT_WIDTH(6), .COUNTER_WIDTH(4), .OFFSET(8), .CENTER_ALIGNED(1)) u_ctr (
    .clk(clk), .rst(rst), .enable(enable), .data_in(c_data), .data_valid(c_valid),
    .data_ready(c_ready), .pwm_out(c_pwm), .period_start(c_ps));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (phase within period) ----------------
  typedef struct {
    int       phase;
    bit       pending;
    bit       oor;
    int       sh [2];
    int       ac [2];
    bit [1:0] pwm;
    bit       ps;
  } mst_t;

  mst_t me, mc;

  function automatic int conv(input logic [5:0] x);
    int v;
    v = int'($signed(x)) + 8;
    if (v < 0) v = 0;
    if (v > 16) v = 16;
    return v;
  endfunction

  function automatic mst_t mstep(input mst_t s, input bit center, input bit r, input bit en,
                                 input bit v, input logic [11:0] d);
    mst_t n;
    int   period, cnt, du;
    bit   bnd, rdy;
    n = s;
    if (r) begin
      n.phase = 0; n.pending = 0; n.oor = 0; n.pwm = 0; n.ps = 0;
      for (int k = 0; k < 2; k++) begin n.sh[k] = 0; n.ac[k] = 0; end
      return n;
    end
    period = center ? 2 * MAXV : MAXV + 1;
    cnt    = (center && s.phase > MAXV) ? 2 * MAXV - s.phase : s.phase;
    bnd    = en && (s.phase == 0);
    rdy    = s.oor && !s.pending;
    for (int k = 0; k < 2; k++) begin
      du = (bnd && s.pending) ? s.sh[k] : s.ac[k];
      n.pwm[k] = en && (cnt < du);
    end
    n.ps = bnd;
    if (bnd && s.pending) begin
      for (int k = 0; k < 2; k++) n.ac[k] = s.sh[k];
      n.pending = 0;
    end
    if (v && rdy) begin
      for (int k = 0; k < 2; k++) n.sh[k] = conv(d[k*6 +: 6]);
      n.pending = 1;
    end
    n.phase = en ? (s.phase + 1) % period : 0;
    n.oor   = 1;
    return n;
  endfunction

  always @(posedge clk) begin
    me = mstep(me, 1'b0, rst, enable, e_valid, e_data);
    mc = mstep(mc, 1'b1, rst, enable, c_valid, c_data);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("edge_model", {e_pwm, e_ps, e_ready}, {me.pwm, me.ps, me.oor & ~me.pending});
      check("ctr_model", {c_pwm, c_ps, c_ready}, {mc.pwm, mc.ps, mc.oor & ~mc.pending});
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ready(input bit center);
    int n;
    n = 0;
    while (((center ? c_ready : e_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(center ? "c_ready_wait" : "e_ready_wait", center ? c_ready : e_ready, 1);
  endtask

  task automatic send_e(input int d0, input int d1);
    wait_ready(1'b0);
    e_data  = {d1[5:0], d0[5:0]};
    e_valid = 1;
    @(negedge clk);
    e_valid = 0;
  endtask

  // Entered on the first output cycle of a period; counts high cycles over one period.
  task automatic measure_e(input int exp0, input int exp1);
    int h0, h1;
    h0 = 0; h1 = 0;
    check("meas_ps_start", e_ps, 1);
    for (int i = 0; i < 16; i++) begin
      h0 += int'(e_pwm[0]);
      h1 += int'(e_pwm[1]);
      @(negedge clk);
    end
    check("meas_high_ch0", h0, exp0);
    check("meas_high_ch1", h1, exp1);
    check("meas_ps_next", e_ps, 1);
  endtask

  typedef struct {
    int s0;
    int s1;
    int h0;
    int h1;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    logic [29:0] pat0, pat1, exp_pat;
    int n, ps_cnt, h;

    vecs[0] = '{0, 4, 8, 12};
    vecs[1] = '{31, -32, 16, 0};
    vecs[2] = '{-8, 7, 0, 15};
    vecs[3] = '{-9, 8, 0, 16};
    vecs[4] = '{1, -1, 9, 7};

    rst = 1; enable = 1;
    e_valid = 0; c_valid = 0; e_data = 0; c_data = 0;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_on = 1;
      check("rst_outputs", {e_pwm, e_ps, e_ready}, 0);
    end
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", {e_ready, c_ready}, 2'b11);

    // center mode, D=4 on ch0 and D=16 on ch1
    c_data  = {6'd8, 6'h3C};
    wait_ready(1'b1);
    c_valid = 1;
    @(negedge clk);
    c_valid = 0;
    wait_ready(1'b1);
    check("ctr_ps_start", c_ps, 1);
    ps_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      pat0[i] = c_pwm[0];
      pat1[i] = c_pwm[1];
      exp_pat[i] = (i < 4) || (i > 26);
      if (i > 0) ps_cnt += int'(c_ps);
      @(negedge clk);
    end
    check("ctr_pattern_d4", pat0, exp_pat);
    check("ctr_pattern_d16", pat1, 30'h3FFFFFFF);
    check("ctr_ps_inside", ps_cnt, 0);
    check("ctr_ps_period30", c_ps, 1);

    // edge mode duty table
    for (int v = 0; v < 5; v++) begin
      send_e(vecs[v].s0, vecs[v].s1);
      wait_ready(1'b0);
      measure_e(vecs[v].h0, vecs[v].h1);
    end

    // handshake: two samples back-to-back mid-period
    repeat (4) @(negedge clk);
    e_data  = {6'd7, 6'h38};   // ch0=-8 (D=0), ch1=7 (D=15)
    e_valid = 1;
    @(negedge clk);
    check("hs_first_taken", e_ready, 0);
    e_data = {6'h38, 6'd0};    // ch0=0 (D=8), ch1=-8 (D=0)
    n = 0;
    while (e_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hs_stall_cycles", n, 11);
    check("hs_ps_at_apply", e_ps, 1);
    check("hs_first_duty", e_pwm, 2'b10);
    @(negedge clk);
    e_valid = 0;
    check("hs_second_taken", e_ready, 0);
    wait_ready(1'b0);
    measure_e(8, 0);

    // reset at count 9 with a pending sample
    send_e(5, 5);
    repeat (7) @(negedge clk);
    check("rst_pending_set", e_ready, 0);
    rst = 1;
    @(negedge clk);
    check("rst_mid_period", {e_pwm, e_ps, e_ready}, 0);
    rst = 0;
    h = 0;
    repeat (40) begin
      @(negedge clk);
      h += int'(e_pwm[0]) + int'(e_pwm[1]);
    end
    check("rst_outputs_low", h, 0);
    check("rst_pending_clear", e_ready, 1);

    // enable drop mid-period
    send_e(10, 10);
    wait_ready(1'b0);
    check("en_full_duty", e_pwm, 2'b11);
    repeat (5) @(negedge clk);
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en_low_outputs", {e_pwm, e_ps}, 0);
    end
    enable = 1;
    @(negedge clk);
    check("en_restart_ps", e_ps, 1);
    check("en_duty_retained", e_pwm, 2'b11);
    repeat (16) @(negedge clk);
    check("en_restart_period", e_ps, 1);

    // randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      enable  = ($urandom_range(0, 15) != 0);
      e_valid = ($urandom_range(0, 3) == 0);
      c_valid = ($urandom_range(0, 3) == 0);
      e_data  = 12'($urandom);
      c_data  = 12'($urandom);
    end
    @(negedge clk);
    rst = 0; enable = 1; e_valid = 0; c_valid = 0;
    repeat (3) @(negedge clk);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator. Next generation of the single-channel audio PWM output stage.
- Adds the following over the single-channel stage:
  - synchronous reset;
  - N channels sharing one counter;
  - signed input with offset and saturation;
  - double-buffered duty updates with a valid/ready handshake;
  - edge- or center-aligned mode;
  - enable control and a period-start strobe.
- Sits between the demodulator/decimator sample stream and the board PWM pins.

Parameters:
- NUM_CH, 2, number of PWM channels.
- INPUT_WIDTH, 12, width of each channel sample, two's complement.
- COUNTER_WIDTH, 10, PWM counter width; MAX = 2^COUNTER_WIDTH - 1.
- OFFSET, 512, unsigned constant added to each signed sample before clamping.
- CENTER_ALIGNED, 0, 0 = edge-aligned sawtooth count, 1 = up/down triangle count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run control; low holds the counter and forces outputs low.
- data_in  in  NUM_CH*INPUT_WIDTH  packed samples; channel k at bits [k*INPUT_WIDTH +: INPUT_WIDTH].
- data_valid  in  1  data_in valid.
- data_ready  out  1  shadow buffer free; a transfer occurs when data_valid && data_ready.
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse marking the first output cycle of each period.

Behaviour:
- Reset, held while rst=1 and applied on the clock edge:
  - count=0, direction=up;
  - active and shadow duty = 0 for all channels;
  - pending=0, pwm_out=0, period_start=0;
  - data_ready=0 while rst=1, then 1 from the first cycle after rst deasserts.
- Reset mid-period aborts the period immediately and discards any pending sample.
- Duty conversion happens at capture, per channel:
  - S = sign-extended sample + OFFSET, computed in INPUT_WIDTH+2 signed bits, no overflow;
  - D = clamp(S, 0, 2^COUNTER_WIDTH), stored in COUNTER_WIDTH+1 bits.
- Handshake:
  - data_ready = !pending (registered state, no combinational path from data_valid);
  - on a transfer, all NUM_CH duties are written to shadow and pending is set;
  - data_in is ignored when data_ready=0.
- Counter, edge mode:
  - increments 0..MAX, then wraps to 0;
  - period is 2^COUNTER_WIDTH cycles.
- Counter, center mode:
  - counts up 0..MAX, then down MAX-1..1, then 0 again;
  - direction flips at MAX and at 0;
  - period is 2*MAX cycles.
- Boundary is the cycle in which enable=1, count=0 and direction=up.
- At a boundary with pending=1:
  - active <= shadow and pending <= 0;
  - data_ready rises on the next cycle.
- If a transfer and a boundary coincide with pending=0:
  - the new sample goes to shadow only;
  - it is applied at the following boundary, never bypassed into the current period.
- Compare:
  - Dn = shadow if (boundary && pending), else active;
  - pwm_out[k] <= (count < Dn[k]) registered, giving one cycle latency from count to pin.
- Resulting duty:
  - D=0 gives a constant low output;
  - D=2^COUNTER_WIDTH gives a constant high output;
  - edge mode: high for exactly D cycles per period, starting at period start;
  - center mode, 1<=D<=MAX: high for 2D-1 cycles, symmetric about the count=0 point.
- period_start is registered as the boundary flag, so it aligns with the pwm_out cycle for count 0.
- Enable:
  - while enable=0: count is held at 0, direction=up, pwm_out=0, period_start=0;
  - the handshake stays operational while enable=0, so shadow may load;
  - the first enabled cycle is a boundary.
- Enable deasserted mid-period: the period is abandoned and the active duty is retained.

Test Plan:
1. Parameters NUM_CH=2, INPUT_WIDTH=6, COUNTER_WIDTH=4, OFFSET=8, edge mode.
   - Stimulus: reset 3 cycles, then load ch0=0, ch1=4.
   - Required: pwm_out=0 and data_ready=0 during reset; from the next boundary, ch0 high 8 of 16 cycles and ch1 high 12 of 16; period_start every 16 cycles.
2. Saturation.
   - Stimulus: ch0=31, ch1=-32.
   - Required: ch0 constant high (D=16), ch1 constant low (D=0); ch0=-8 also gives constant low.
3. Handshake.
   - Stimulus: present two samples back-to-back mid-period.
   - Required: first accepted, data_ready drops; second held until the cycle after the boundary; neither duty takes effect before its boundary.
4. Center mode, CENTER_ALIGNED=1, COUNTER_WIDTH=4.
   - Stimulus: D=4.
   - Required: period 30 cycles; high 7 consecutive cycles spanning count values 3,2,1,0,1,2,3 (centered on the count=0 boundary cycle); period_start on the count-0 cycle.
5. Reset and enable.
   - Stimulus: assert rst at count=9 with pending=1.
   - Required: next cycle pwm_out=0, pending cleared; after release, outputs stay low until a new sample is loaded.
   - Stimulus: drop enable for 5 cycles.
   - Required: pwm_out low and count held at 0; restart with period_start on the first enabled cycle.
